// File: rtl/cam_lookup_ctrl.sv
// Lookup/allocate sequencer for a small match CAM: one request in flight, hit/miss
// response with an entry index, and invalid-first then round-robin replacement.
module cam_lookup_ctrl #(
    parameter int TAG_W   = 8,
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               req_alloc,
    input  logic               flush,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_hit,
    output logic [IDX_W-1:0]   resp_idx,
    output logic               resp_alloc,
    output logic               resp_multi,
    output logic               cam_we_n,
    output logic               cam_rd_n,
    output logic [TAG_W-1:0]   cam_din,
    output logic [TAG_W-1:0]   cam_argin,
    output logic [IDX_W-1:0]   cam_addrs,
    input  logic [ENTRIES-1:0] cam_mbits
);

    typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, WRITE, RESP} state_t;

    state_t             state, state_nxt;
    logic [ENTRIES-1:0] valid, valid_nxt, match, match_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [TAG_W-1:0]   tag, tag_nxt;
    logic               alloc, alloc_nxt;
    logic               resp_valid_nxt, resp_hit_nxt, resp_alloc_nxt, resp_multi_nxt;
    logic [IDX_W-1:0]   resp_idx_nxt;
    logic               cam_we_n_nxt;
    logic [TAG_W-1:0]   cam_din_nxt, cam_argin_nxt;
    logic [IDX_W-1:0]   cam_addrs_nxt;
    logic [IDX_W-1:0]   hit_idx, inv_idx;
    logic               inv_any, multi;

    // The CAM's dout is never used, so its read enable stays parked low.
    assign cam_rd_n  = 1'b0;
    assign req_ready = (state == IDLE) && !flush;

    always_comb begin
        hit_idx = '0;
        inv_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i])  hit_idx = IDX_W'(i);
            if (!valid[i]) inv_idx = IDX_W'(i);
        end
        inv_any = ~&valid;
        multi   = (match & (match - ENTRIES'(1))) != '0;
    end

    always_comb begin
        state_nxt      = state;
        valid_nxt      = valid;
        match_nxt      = match;
        rr_nxt         = rr_ptr;
        tag_nxt        = tag;
        alloc_nxt      = alloc;
        resp_valid_nxt = resp_valid;
        resp_hit_nxt   = resp_hit;
        resp_idx_nxt   = resp_idx;
        resp_alloc_nxt = resp_alloc;
        resp_multi_nxt = resp_multi;
        cam_we_n_nxt   = 1'b0;
        cam_din_nxt    = cam_din;
        cam_argin_nxt  = cam_argin;
        cam_addrs_nxt  = cam_addrs;
        case (state)
            IDLE: begin
                if (flush) begin
                    valid_nxt = '0;
                    rr_nxt    = '0;
                end else if (req_valid) begin
                    tag_nxt       = req_tag;
                    alloc_nxt     = req_alloc;
                    cam_argin_nxt = req_tag;
                    state_nxt     = LOOKUP;
                end
            end
            LOOKUP: begin
                match_nxt = cam_mbits & valid;
                state_nxt = DECIDE;
            end
            DECIDE: begin
                if (match != '0) begin
                    resp_hit_nxt   = 1'b1;
                    resp_idx_nxt   = hit_idx;
                    resp_alloc_nxt = 1'b0;
                    resp_multi_nxt = multi;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = RESP;
                end else if (!alloc) begin
                    resp_hit_nxt   = 1'b0;
                    resp_idx_nxt   = '0;
                    resp_alloc_nxt = 1'b0;
                    resp_multi_nxt = 1'b0;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = RESP;
                end else begin
                    cam_addrs_nxt = inv_any ? inv_idx : rr_ptr;
                    if (!inv_any) rr_nxt = rr_ptr + IDX_W'(1);
                    cam_din_nxt   = tag;
                    cam_we_n_nxt  = 1'b1;
                    state_nxt     = WRITE;
                end
            end
            WRITE: begin
                // cam_addrs/cam_din are left untouched so they outlive the strobe.
                valid_nxt[cam_addrs] = 1'b1;
                resp_hit_nxt   = 1'b0;
                resp_idx_nxt   = cam_addrs;
                resp_alloc_nxt = 1'b1;
                resp_multi_nxt = 1'b0;
                resp_valid_nxt = 1'b1;
                state_nxt      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            match      <= '0;
            rr_ptr     <= '0;
            tag        <= '0;
            alloc      <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
            resp_alloc <= 1'b0;
            resp_multi <= 1'b0;
            cam_we_n   <= 1'b0;
            cam_din    <= '0;
            cam_argin  <= '0;
            cam_addrs  <= '0;
        end else begin
            state      <= state_nxt;
            valid      <= valid_nxt;
            match      <= match_nxt;
            rr_ptr     <= rr_nxt;
            tag        <= tag_nxt;
            alloc      <= alloc_nxt;
            resp_valid <= resp_valid_nxt;
            resp_hit   <= resp_hit_nxt;
            resp_idx   <= resp_idx_nxt;
            resp_alloc <= resp_alloc_nxt;
            resp_multi <= resp_multi_nxt;
            cam_we_n   <= cam_we_n_nxt;
            cam_din    <= cam_din_nxt;
            cam_argin  <= cam_argin_nxt;
            cam_addrs  <= cam_addrs_nxt;
        end
    end

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Bench for cam_lookup_ctrl: behavioural CAM plus an array-based reference of the
// lookup/allocate rules, directed scenarios followed by randomized lookups.
module tb_cam_lookup_ctrl;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_alloc, flush, resp_ready;
    logic       req_ready, resp_valid, resp_hit, resp_alloc, resp_multi;
    logic [7:0] req_tag, cam_din, cam_argin;
    logic [1:0] resp_idx, cam_addrs;
    logic       cam_we_n, cam_rd_n;
    logic [3:0] cam_mbits;

    int checks = 0;
    int errors = 0;

    // CAM model: writes while cam_we_n is high, powers up holding 8'hFF
    logic [7:0] cam_mem [4] = '{default: 8'hFF};
    logic       frc_we = 1'b0;
    logic [1:0] frc_addr = '0;
    logic [7:0] frc_data = '0;

    always @(posedge clk) begin
        if (cam_we_n)    cam_mem[cam_addrs] <= cam_din;
        else if (frc_we) cam_mem[frc_addr]  <= frc_data;
    end

    always_comb begin
        cam_mbits = '0;
        for (int i = 0; i < 4; i++) cam_mbits[i] = (cam_mem[i] == cam_argin);
    end

    always #5 clk = ~clk;

    cam_lookup_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_alloc(req_alloc), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_idx(resp_idx), .resp_alloc(resp_alloc), .resp_multi(resp_multi),
        .cam_we_n(cam_we_n), .cam_rd_n(cam_rd_n), .cam_din(cam_din),
        .cam_argin(cam_argin), .cam_addrs(cam_addrs), .cam_mbits(cam_mbits)
    );

    // reference state
    logic [7:0] ref_tag [4];
    bit         ref_valid [4];
    int         ref_rr;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic void ref_clear();
        for (int i = 0; i < 4; i++) ref_valid[i] = 0;
        ref_rr = 0;
    endfunction

    function automatic void ref_lookup(input logic [7:0] t, input logic al,
                                       output logic hit, output logic [1:0] idx,
                                       output logic did_alloc, output logic multi);
        int cnt = 0;
        int first = -1;
        int victim = -1;
        hit = 0; idx = 0; did_alloc = 0; multi = 0;
        for (int i = 0; i < 4; i++)
            if (ref_valid[i] && ref_tag[i] == t) begin
                cnt++;
                if (first < 0) first = i;
            end
        if (cnt > 0) begin
            hit   = 1;
            idx   = 2'(first);
            multi = (cnt > 1);
        end else if (al) begin
            for (int i = 3; i >= 0; i--) if (!ref_valid[i]) victim = i;
            if (victim < 0) begin
                victim = ref_rr;
                ref_rr = (ref_rr + 1) % 4;
            end
            ref_tag[victim]   = t;
            ref_valid[victim] = 1;
            idx       = 2'(victim);
            did_alloc = 1;
        end
    endfunction

    task automatic do_lookup(input logic [7:0] t, input logic al, input int hold);
        logic       e_hit, e_alloc, e_multi;
        logic [1:0] e_idx, we_addr;
        logic [7:0] we_din;
        int         we_cnt, lat;
        ref_lookup(t, al, e_hit, e_idx, e_alloc, e_multi);
        @(negedge clk);
        req_valid = 1'b1; req_tag = t; req_alloc = al;
        #1 chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        we_cnt = 0; lat = 0; we_addr = '0; we_din = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (cam_we_n === 1'b1) begin
                we_cnt++;
                we_addr = cam_addrs;
                we_din  = cam_din;
            end
            if (resp_valid === 1'b1) lat = c;
        end
        if (lat == 0) begin
            checks++; errors++;
            $error("FAIL resp_timeout: observed=no resp_valid expected=resp_valid within 8 cycles");
            return;
        end
        chk("latency", lat, e_alloc ? 4 : 3);
        chk("we_pulses", we_cnt, e_alloc ? 1 : 0);
        if (e_alloc) begin
            chk("we_addr", we_addr, e_idx);
            chk("we_din", we_din, t);
            chk("addr_after_we", cam_addrs, e_idx);
            chk("din_after_we", cam_din, t);
        end
        chk("cam_argin", cam_argin, t);
        chk("resp_hit", resp_hit, e_hit);
        chk("resp_idx", resp_idx, e_idx);
        chk("resp_alloc", resp_alloc, e_alloc);
        chk("resp_multi", resp_multi, e_multi);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("resp_hold", {resp_valid, resp_hit, resp_idx, resp_alloc, resp_multi, req_ready, cam_we_n},
                {1'b1, e_hit, e_idx, e_alloc, e_multi, 1'b0, 1'b0});
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_cleared", resp_valid, 0);
        chk("ready_after_hs", req_ready, 1);
    endtask

    task automatic do_flush_with_req();
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_tag = 8'($urandom); req_alloc = 1'b1;
        #1 chk("ready_during_flush", req_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0; req_valid = 1'b0;
        ref_clear();
        @(negedge clk);
        chk("no_accept_on_flush", {resp_valid, req_ready, cam_we_n}, 3'b010);
    endtask

    task automatic do_force(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        frc_we = 1'b1; frc_addr = a; frc_data = d;
        @(posedge clk);
        #1 frc_we = 1'b0;
        ref_tag[a] = d;
    endtask

    task automatic reset_in_write(input logic [7:0] t);
        @(negedge clk);
        req_valid = 1'b1; req_tag = t; req_alloc = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("we_in_write", cam_we_n, 1);
        rst = 1'b1;
        #1;
        chk("rst_we", cam_we_n, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_idle", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        ref_clear();
    endtask

    logic [7:0] pool [6] = '{8'h3A, 8'h5C, 8'hFF, 8'h10, 8'h77, 8'hC4};

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_alloc = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        req_tag = '0;
        for (int i = 0; i < 4; i++) ref_tag[i] = 8'hFF;
        ref_clear();
        repeat (3) @(negedge clk);
        chk("rst_outputs", {resp_valid, resp_hit, resp_idx, resp_alloc, resp_multi, cam_we_n, cam_rd_n},
            8'h00);
        chk("rst_cam_bus", {cam_din, cam_argin, cam_addrs}, 18'h0);
        chk("rst_ready", req_ready, 1);
        rst = 1'b0;

        do_lookup(8'hFF, 1'b0, 0);
        do_lookup(8'h3A, 1'b1, 0);
        do_lookup(8'h5C, 1'b1, 1);
        do_lookup(8'h77, 1'b1, 0);
        do_lookup(8'h01, 1'b1, 2);
        do_lookup(8'h5C, 1'b0, 0);
        do_lookup(8'h99, 1'b1, 0);
        do_lookup(8'hAB, 1'b1, 0);
        do_lookup(8'h3A, 1'b0, 0);
        do_force(2'd1, 8'h10);
        do_force(2'd3, 8'h10);
        do_lookup(8'h10, 1'b0, 0);
        do_lookup(8'h77, 1'b0, 5);
        do_flush_with_req();
        do_lookup(8'h77, 1'b0, 0);
        do_lookup(8'h99, 1'b0, 0);
        reset_in_write(8'h42);
        do_lookup(8'h42, 1'b0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [7:0] t;
            t = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 11) == 0) do_flush_with_req();
            do_lookup(t, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
